encoder64_6_walk: RTL and testbench
===================================

# encoder64_6_walk

Serialising 64-to-6 encoder: accepts a 64-bit request vector over a valid/ready handshake and emits the 6-bit index of every set bit, one index per accepted output beat, until the vector is exhausted. It is the inverse partner of the 6-to-64 one-hot decoders used for FIFO slot selection. It converts occupancy/request bitmaps back into binary slot addresses for the read side of the FIFO datapath.

## Interface
Parameters:
- none; widths are fixed at 64 request bits / 6 index bits.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- enable  input  1  global run enable; when low the block freezes (no handshakes complete)
- in_valid  input  1  request vector present on in_vec
- in_vec  input  64  request bitmap; bit i set = index i to be emitted
- in_ready  output  1  block can accept a new vector
- out_valid  output  1  out_index holds a valid index
- out_index  output  6  binary index of currently selected set bit
- out_last  output  1  current index is the final set bit of the vector
- out_ready  input  1  downstream accepts out_index this cycle

## Operation
- Registers: pending[63:0], state (IDLE/BUSY), ptr[5:0] (search start).
- Reset values: pending=0, state=IDLE, ptr=0; outputs in_ready=0 while rst high, then 1; out_valid=0, out_index=0, out_last=0.
- in_ready = enable & (state==IDLE). out_valid = enable & (state==BUSY).
- IDLE: on in_valid & in_ready: if in_vec!=0 -> pending<=in_vec, state<=BUSY; if in_vec==0 -> vector consumed, state stays IDLE, nothing emitted.
- BUSY: out_index = first set bit of pending found by searching upward from ptr, wrapping 63->0 (combinational from registers). out_last = 1 when exactly one bit of pending is set.
- On out_valid & out_ready: pending[out_index]<=0; ptr<=out_index+1 (mod 64, 63 wraps to 0); if out_last, state<=IDLE.
- No new vector is accepted while BUSY; in_vec is ignored then.
- enable low: handshakes suppressed on both sides, all registers hold; out_index/out_last still reflect pending.
- Reset asserted mid-vector: pending cleared, state IDLE, ptr 0 immediately (asynchronous); remaining indices discarded.

## Timing
- Latency: vector accepted at edge N -> first index valid in cycle after N (1 cycle).
- Throughput: one index per cycle while out_ready held high; vector with k set bits occupies k BUSY cycles minimum.
- Back-to-back: last beat accepted at edge M -> state IDLE, in_ready high in cycle after M; earliest next first index one cycle after that (one bubble per vector).
- out_index/out_last stable while out_valid & !out_ready (pending and ptr unchanged).

## Configuration
- ENC64_ROUND_ROBIN_EN defined: search starts at ptr, which persists across vectors (fair rotation among slots).
- Not defined: ptr is forced to 0 and never updated; search always starts at bit 0, i.e. strict lowest-index-first, ascending order within every vector.

## Test plan
- Reset, send in_vec=64'h0000_0000_0000_0001, out_ready=1 -> one beat out_index=0, out_last=1; in_ready high again 2 cycles after accept.
- in_vec=64'h8000_0000_0000_0011, out_ready=1, macro off -> indices 0,4,63 on consecutive cycles, out_last only on 63.
- Macro on: first vector 64'h0000_0000_0000_0020 (emits 5, ptr=6), then 64'h0000_0000_0000_0041 -> emits 6 then 0 (wrap), out_last on 0.
- in_vec=0 accepted -> out_valid never rises, in_ready stays high next cycle.
- Backpressure/enable: vector 64'h0F, out_ready low 3 cycles then high, enable pulsed low mid-burst -> out_index held at 0 during stall, sequence 0,1,2,3 with no loss or duplication.
- Assert rst after second beat of 64'hFF -> out_valid=0 and in_ready=1 after release; new vector 64'h2 emits index 1 only.

Source files
------------

// File: rtl/encoder64_6_walk.sv
// encoder64_6_walk: serialising 64-to-6 encoder.
// Takes a 64-bit request bitmap over valid/ready and emits the binary index
// of every set bit, one per output handshake, flagging the final one.
// Optional feature macro: ENC64_ROUND_ROBIN_EN -- when defined the search
// start pointer persists across vectors (fair rotation); when undefined the
// search always starts at bit 0 (strict ascending order).
module encoder64_6_walk (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        in_valid,
    input  logic [63:0] in_vec,
    output logic        in_ready,
    output logic        out_valid,
    output logic [5:0]  out_index,
    output logic        out_last,
    input  logic        out_ready
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_q;
    logic [63:0] pending_q;
    logic [63:0] pending_d;
    logic [63:0] rot;
    logic [5:0]  off;
    logic [5:0]  ptr;
    logic        accept_in;
    logic        accept_out;

`ifdef ENC64_ROUND_ROBIN_EN
    logic [5:0]  ptr_q;
    assign ptr = ptr_q;
`else
    // Fixed search origin: lowest index first within every vector.
    assign ptr = 6'd0;
`endif

    // Handshakes; in_ready is held low for the whole time reset is asserted.
    assign in_ready   = enable & ~rst & (state_q == IDLE);
    assign out_valid  = enable & (state_q == BUSY);
    assign accept_in  = in_valid & in_ready;
    assign accept_out = out_valid & out_ready;

    // Rotate pending so bit ptr lands at position 0, then pick the lowest set
    // bit; adding ptr back (mod 64) gives the wrapped upward search result.
    // A shift of 64 (ptr == 0) yields zero, so the wrap term vanishes there.
    always_comb begin
        rot = (pending_q >> ptr) | (pending_q << (7'd64 - {1'b0, ptr}));
        off = 6'd0;
        for (int i = 63; i >= 0; i--) begin
            if (rot[i]) off = i[5:0];
        end
    end

    assign out_index = off + ptr;
    // Exactly one bit left: non-zero and clearing the lowest bit leaves zero.
    assign out_last  = (pending_q != 64'd0) &&
                       ((pending_q & (pending_q - 64'd1)) == 64'd0);
    assign pending_d = pending_q & ~(64'd1 << out_index);

    // Control FSM: load a non-empty vector in IDLE, retire one index per beat in BUSY.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= 64'd0;
`ifdef ENC64_ROUND_ROBIN_EN
            ptr_q     <= 6'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    // An all-zero vector is consumed without producing beats.
                    if (accept_in && (in_vec != 64'd0)) begin
                        pending_q <= in_vec;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    if (accept_out) begin
                        pending_q <= pending_d;
`ifdef ENC64_ROUND_ROBIN_EN
                        ptr_q     <= out_index + 6'd1;
`endif
                        if (out_last) state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_encoder64_6_walk.sv
// tb_encoder64_6_walk: directed self-checking bench for encoder64_6_walk.
// Inputs driven 1 time unit after the rising edge; outputs sampled there too.
module tb_encoder64_6_walk;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        in_valid;
    logic [63:0] in_vec;
    logic        in_ready;
    logic        out_valid;
    logic [5:0]  out_index;
    logic        out_last;
    logic        out_ready;

    int total = 0;
    int bad   = 0;

    encoder64_6_walk dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .in_valid  (in_valid),
        .in_vec    (in_vec),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_index (out_index),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one vector; waits (bounded) for in_ready, then holds valid for one edge.
    task automatic send(input logic [63:0] v);
        int n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        chk("send_rdy", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        in_vec   = v;
        step();
        in_valid = 1'b0;
        in_vec   = 64'd0;
    endtask

    // Check the beat presented this cycle and let it be taken at the next edge.
    task automatic beat(input string tag, input logic [5:0] idx, input logic last);
        chk({tag, "_v"},    {63'd0, out_valid}, 64'd1);
        chk({tag, "_idx"},  {58'd0, out_index}, {58'd0, idx});
        chk({tag, "_last"}, {63'd0, out_last},  {63'd0, last});
        step();
    endtask

    // Single bit 63: emits 63 and leaves the round-robin pointer at 0.
    task automatic sync_ptr();
        send(64'h8000_0000_0000_0000);
        beat("sync", 6'd63, 1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        enable    = 1'b1;
        in_valid  = 1'b0;
        in_vec    = 64'd0;
        out_ready = 1'b1;
        step();
        step();
        chk("rst_in_ready",  {63'd0, in_ready},  64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_index", {58'd0, out_index}, 64'd0);
        chk("rst_out_last",  {63'd0, out_last},  64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", {63'd0, in_ready}, 64'd1);

        // Single bit 0: one beat, in_ready back one cycle after the beat.
        send(64'h0000_0000_0000_0001);
        beat("one", 6'd0, 1'b1);
        chk("one_idle_v",   {63'd0, out_valid}, 64'd0);
        chk("one_idle_rdy", {63'd0, in_ready},  64'd1);

        // Bits 0, 4, 63 on consecutive cycles.
        sync_ptr();
        send(64'h8000_0000_0000_0011);
        beat("t2a", 6'd0,  1'b0);
        beat("t2b", 6'd4,  1'b0);
        beat("t2c", 6'd63, 1'b1);

        // Pointer after bit 5 is 6: round-robin visits 6 then wraps to 0.
        send(64'h0000_0000_0000_0020);
        beat("rr5", 6'd5, 1'b1);
        send(64'h0000_0000_0000_0041);
`ifdef ENC64_ROUND_ROBIN_EN
        beat("rra", 6'd6, 1'b0);
        beat("rrb", 6'd0, 1'b1);
`else
        beat("rra", 6'd0, 1'b0);
        beat("rrb", 6'd6, 1'b1);
`endif

        // Empty vector is consumed silently.
        send(64'd0);
        chk("zero_v",   {63'd0, out_valid}, 64'd0);
        chk("zero_rdy", {63'd0, in_ready},  64'd1);
        step();
        chk("zero_v2",  {63'd0, out_valid}, 64'd0);

        // Backpressure then enable dropout mid-burst.
        sync_ptr();
        out_ready = 1'b0;
        send(64'h0000_0000_0000_000F);
        for (int i = 0; i < 3; i++) begin
            chk("stall_v",    {63'd0, out_valid}, 64'd1);
            chk("stall_idx",  {58'd0, out_index}, 64'd0);
            chk("stall_last", {63'd0, out_last},  64'd0);
            step();
        end
        out_ready = 1'b1;
        beat("bp0", 6'd0, 1'b0);
        beat("bp1", 6'd1, 1'b0);
        enable = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("en_v",   {63'd0, out_valid}, 64'd0);
            chk("en_rdy", {63'd0, in_ready},  64'd0);
            chk("en_idx", {58'd0, out_index}, 64'd2);
            step();
        end
        enable = 1'b1;
        #1;
        beat("bp2", 6'd2, 1'b0);
        beat("bp3", 6'd3, 1'b1);

        // Reset in the middle of a vector discards the rest.
        sync_ptr();
        send(64'h0000_0000_0000_00FF);
        beat("ff0", 6'd0, 1'b0);
        beat("ff1", 6'd1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_v",    {63'd0, out_valid}, 64'd0);
        chk("mid_rst_rdy",  {63'd0, in_ready},  64'd0);
        chk("mid_rst_idx",  {58'd0, out_index}, 64'd0);
        chk("mid_rst_last", {63'd0, out_last},  64'd0);
        step();
        rst = 1'b0;
        #1;
        chk("rel_rdy", {63'd0, in_ready},  64'd1);
        chk("rel_v",   {63'd0, out_valid}, 64'd0);
        step();
        chk("rel_v2",  {63'd0, out_valid}, 64'd0);
        send(64'h0000_0000_0000_0002);
        beat("after", 6'd1, 1'b1);
        chk("end_v",   {63'd0, out_valid}, 64'd0);
        chk("end_rdy", {63'd0, in_ready},  64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
